// File: rtl/mux_key_match_pipe.sv
// Programmable key-match lookup table with a one-stage handshaked result register.
// Optional macro KEY_MATCH_PRIO_EN makes o_resp_match one-hot on the lowest matching entry.
module mux_key_match_pipe #(
  parameter int NR_KEY    = 4,
  parameter int KEY_WIDTH = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [IDX_WIDTH-1:0] i_wr_idx,
  input  logic [KEY_WIDTH-1:0] i_wr_key,
  input  logic                 i_clr,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [KEY_WIDTH-1:0] i_req_key,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [NR_KEY-1:0]    o_resp_match,
  output logic [IDX_WIDTH-1:0] o_resp_idx,
  output logic                 o_resp_hit,
  output logic                 o_resp_multi
);

  // True when more than one bit of the vector is set.
  function automatic logic f_multi(input logic [NR_KEY-1:0] vec);
    return |(vec & (vec - NR_KEY'(1'b1)));
  endfunction

  logic [KEY_WIDTH-1:0] r_key [NR_KEY];
  logic [NR_KEY-1:0]    r_valid;

  logic                 r_resp_valid;
  logic [NR_KEY-1:0]    r_resp_match;
  logic [IDX_WIDTH-1:0] r_resp_idx;
  logic                 r_resp_hit;
  logic                 r_resp_multi;

  logic                 w_accept;
  logic [NR_KEY-1:0]    w_raw;
  logic [NR_KEY-1:0]    w_match;
  logic [IDX_WIDTH-1:0] w_idx;
  logic                 w_hit;
  logic                 w_multi;

  assign o_req_ready = !r_resp_valid || i_resp_ready;
  assign w_accept    = i_req_valid && o_req_ready;

  // Table storage: clr wipes valid bits, a same-cycle in-range write wins for its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        r_key[i] <= '0;
      end
    end else begin
      if (i_clr) begin
        r_valid <= '0;
      end else begin
        r_valid <= r_valid;
      end
      // Only indices below NR_KEY ever compare equal, so out-of-range writes vanish.
      for (int i = 0; i < NR_KEY; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_WIDTH'(i))) begin
          r_key[i]   <= i_wr_key;
          r_valid[i] <= 1'b1;
        end else begin
          r_key[i]   <= r_key[i];
        end
      end
    end
  end

  // Compare the request against the pre-edge table and pick the lowest match.
  always_comb begin
    w_raw = '0;
    w_idx = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_raw[i] = r_valid[i] && (r_key[i] == i_req_key);
    end
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      w_idx = w_raw[i] ? IDX_WIDTH'(i) : w_idx;
    end
    w_hit   = |w_raw;
    w_multi = f_multi(w_raw);
`ifdef KEY_MATCH_PRIO_EN
    w_match = w_hit ? (NR_KEY'(1'b1) << w_idx) : '0;
`else
    w_match = w_raw;
`endif
  end

  // Result register: load on accept, drop valid when drained, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_match <= '0;
      r_resp_idx   <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_multi <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_match <= w_match;
      r_resp_idx   <= w_idx;
      r_resp_hit   <= w_hit;
      r_resp_multi <= w_multi;
    end else if (i_resp_ready) begin
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= r_resp_valid;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_match = r_resp_match;
  assign o_resp_idx   = r_resp_idx;
  assign o_resp_hit   = r_resp_hit;
  assign o_resp_multi = r_resp_multi;

endmodule
